// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock period monitor: channel FSM encoding,
// channel index names and the averaging limit.
package clk_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FIRST = 3'd1,
    ST_COUNT      = 3'd2,
    ST_DONE       = 3'd3,
    ST_TOUT       = 3'd4
  } ch_state_e;

  // Default channel assignment of the codec clocks.
  localparam int unsigned CH_MCLK  = 0;
  localparam int unsigned CH_BCLK  = 1;
  localparam int unsigned CH_LRCLK = 2;

  // Largest supported averaging exponent (16 periods).
  localparam int unsigned AVG_LOG2_MAX = 4;

  // A channel is live while it is still waiting for or counting periods.
  function automatic logic is_live(input ch_state_e s);
    return (s == ST_WAIT_FIRST) || (s == ST_COUNT);
  endfunction

endpackage

// File: rtl/clk_period_meter.sv
// One monitored clock: synchronizer, rising-edge detector, channel FSM,
// period counter and averaging accumulator.
// Optional duty measurement is built when CLK_MON_DUTY_MEAS_EN is defined.
module clk_period_meter
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned AVG_LOG2    = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             start,
  input  logic             cont_mode,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             tout
`ifdef CLK_MON_DUTY_MEAS_EN
  ,
  output logic [CNT_W-1:0] high_cnt
`endif
);

  localparam int unsigned ACC_W  = CNT_W + AVG_LOG2;
  localparam int unsigned NPER_W = AVG_LOG2 + 1;
  localparam logic [NPER_W-1:0] NPER_FULL = NPER_W'(1) << AVG_LOG2;
  localparam logic [CNT_W:0]    TOUT_CNT  = (CNT_W + 1)'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [NPER_W-1:0]      nper_q, nper_d;
  logic                   cont_q, cont_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   vld_q, vld_d;
  logic                   tout_q, tout_d;

  logic             synced, rise;
  logic [CNT_W:0]   cnt_inc;
  logic             cnt_hit;
  logic [ACC_W-1:0] acc_sum;
  logic [NPER_W-1:0] nper_inc;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~prev_q;
  // One bit wider so the timeout compare never sees a wrapped count.
  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
  assign cnt_hit  = (cnt_inc == TOUT_CNT);
  assign acc_sum  = acc_q + ACC_W'(cnt_q);
  assign nper_inc = nper_q + 1'b1;

`ifdef CLK_MON_DUTY_MEAS_EN
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [ACC_W-1:0] hacc_q, hacc_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [ACC_W-1:0] hacc_sum;

  assign hacc_sum = hacc_q + ACC_W'(hi_q);
`endif

  // Next-state logic: edge detection, channel FSM, counting and averaging.
  always_comb begin
    // NOTE: every _d takes its hold value before the case, so no branch can
    // leave one unassigned and infer a latch.
    sync_d   = {sync_q[SYNC_STAGES-2:0], mon_clk};
    prev_d   = synced;
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    nper_d   = nper_q;
    cont_d   = cont_q;
    period_d = period_q;
    vld_d    = vld_q;
    tout_d   = tout_q;
`ifdef CLK_MON_DUTY_MEAS_EN
    hi_d   = hi_q;
    hacc_d = hacc_q;
    high_d = high_q;
    // High-phase length restarts at each rise; the rise cycle itself is high.
    if (is_live(state_q)) begin
      if (rise) begin
        hi_d = CNT_W'(1);
      end else if (synced) begin
        hi_d = hi_q + 1'b1;
      end
    end
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (start) begin
          state_d = ST_WAIT_FIRST;
          cnt_d   = '0;
          acc_d   = '0;
          nper_d  = '0;
          tout_d  = 1'b0;
          vld_d   = 1'b0;
          cont_d  = cont_mode;
`ifdef CLK_MON_DUTY_MEAS_EN
          hi_d    = '0;
          hacc_d  = '0;
`endif
        end
      end

      ST_WAIT_FIRST: begin
        if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_COUNT;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_hit) begin
            state_d = ST_TOUT;
            tout_d  = 1'b1;
          end
        end
      end

      ST_COUNT: begin
        if (rise) begin
          // The closing rise of one period opens the next, so cnt restarts at 1.
          cnt_d = CNT_W'(1);
          if (nper_inc == NPER_FULL) begin
            period_d = acc_sum[ACC_W-1:AVG_LOG2];
            vld_d    = 1'b1;
            acc_d    = '0;
            nper_d   = '0;
`ifdef CLK_MON_DUTY_MEAS_EN
            high_d   = hacc_sum[ACC_W-1:AVG_LOG2];
            hacc_d   = '0;
`endif
            if (!cont_q) begin
              state_d = ST_DONE;
            end
          end else begin
            acc_d  = acc_sum;
            nper_d = nper_inc;
`ifdef CLK_MON_DUTY_MEAS_EN
            hacc_d = hacc_sum;
`endif
          end
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_hit) begin
            state_d = ST_TOUT;
            tout_d  = 1'b1;
            vld_d   = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      nper_q   <= '0;
      cont_q   <= 1'b0;
      period_q <= '0;
      vld_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      nper_q   <= nper_d;
      cont_q   <= cont_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      tout_q   <= tout_d;
    end
  end

`ifdef CLK_MON_DUTY_MEAS_EN
  // Duty measurement registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      hacc_q <= '0;
      high_q <= '0;
    end else begin
      hi_q   <= hi_d;
      hacc_q <= hacc_d;
      high_q <= high_d;
    end
  end

  assign high_cnt = high_q;
`endif

  assign busy       = is_live(state_q);
  assign period     = period_q;
  assign period_vld = vld_q;
  assign tout       = tout_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Period monitor for NUM_CH asynchronous clocks (default m_clk, b_clk,
// dac_lr_clk). Aggregates busy/done and packs per-channel results, channel 0
// in the LSBs. The high_cnt port exists only when CLK_MON_DUTY_MEAS_EN is
// defined. reset must be released synchronously to clk upstream.
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned AVG_LOG2    = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       mon_clk,
  input  logic                    start,
  input  logic                    cont_mode,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH-1:0]       period_vld,
  output logic [NUM_CH-1:0]       tout
`ifdef CLK_MON_DUTY_MEAS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] high_cnt
`endif
);

  // Out-of-range averaging requests are clamped to the supported maximum.
  localparam int unsigned AVG_EFF = (AVG_LOG2 > AVG_LOG2_MAX) ? AVG_LOG2_MAX : AVG_LOG2;

  logic [NUM_CH-1:0] ch_busy;
  logic              start_acc;
  logic              busy_prev_q, busy_prev_d;

  assign busy      = |ch_busy;
  // A start arriving while any channel is live is dropped for all channels.
  assign start_acc = start & ~busy;
  assign done      = busy_prev_q & ~busy;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_period_meter #(
      .CNT_W       (CNT_W),
      .AVG_LOG2    (AVG_EFF),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
    ) u_meter (
      .clk        (clk),
      .reset      (reset),
      .mon_clk    (mon_clk[g]),
      .start      (start_acc),
      .cont_mode  (cont_mode),
      .busy       (ch_busy[g]),
      .period     (period[g*CNT_W +: CNT_W]),
      .period_vld (period_vld[g]),
      .tout       (tout[g])
`ifdef CLK_MON_DUTY_MEAS_EN
      ,
      .high_cnt   (high_cnt[g*CNT_W +: CNT_W])
`endif
    );
  end

  // Previous busy, for the falling-edge done pulse.
  always_comb begin
    busy_prev_d = busy;
  end

  // Busy history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_prev_q <= 1'b0;
    end else begin
      busy_prev_q <= busy_prev_d;
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Randomized scoreboard bench for clk_period_monitor. Monitored clocks are
// built from lists of (high, low) phase lengths; expected results are the
// truncated mean of each window of periods taken from those lists.
module tb_clk_period_monitor;
  import clk_mon_pkg::*;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 16;
  localparam int AVG_LOG2    = 2;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 1500;
  localparam int NPER        = 1 << AVG_LOG2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [NUM_CH-1:0]       mon_clk = '0;
  logic                    start = 1'b0;
  logic                    cont_mode = 1'b0;
  logic                    busy, done;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH-1:0]       period_vld, tout;
`ifdef CLK_MON_DUTY_MEAS_EN
  logic [NUM_CH*CNT_W-1:0] high_cnt;
`endif

  clk_period_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2),
    .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .mon_clk(mon_clk), .start(start),
    .cont_mode(cont_mode), .busy(busy), .done(done), .period(period),
    .period_vld(period_vld), .tout(tout)
`ifdef CLK_MON_DUTY_MEAS_EN
    , .high_cnt(high_cnt)
`endif
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0][CNT_W-1:0] per;
    logic [NUM_CH-1:0][CNT_W-1:0] hi;
    logic [NUM_CH-1:0]            vld;
    logic [NUM_CH-1:0]            tout;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic [CNT_W-1:0] chg_q[NUM_CH][$];
  int   ph[NUM_CH][$];
  int   pl[NUM_CH][$];
  bit   wave_q[NUM_CH][$];
  bit   cont_chk = 1'b0;
  logic [NUM_CH-1:0][CNT_W-1:0] last_per = '0;
  logic [NUM_CH-1:0]            seen_vld = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int win_per(input int c, input int w);
    int s = 0;
    for (int k = 0; k < NPER; k++) s += ph[c][w*NPER+k] + pl[c][w*NPER+k];
    return s / NPER;
  endfunction

  function automatic int win_hi(input int c, input int w);
    int s = 0;
    for (int k = 0; k < NPER; k++) s += ph[c][w*NPER+k];
    return s / NPER;
  endfunction

  function automatic exp_t single_exp();
    exp_t e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ph[c].size() >= NPER) begin
        e.vld[c] = 1'b1;
        e.per[c] = CNT_W'(win_per(c, 0));
        e.hi[c]  = CNT_W'(win_hi(c, 0));
      end else begin
        e.tout[c] = 1'b1;
      end
    end
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_lists();
    for (int c = 0; c < NUM_CH; c++) begin
      ph[c].delete(); pl[c].delete();
    end
  endtask

  task automatic add_const(input int c, input int n, input int h, input int l);
    for (int k = 0; k < n; k++) begin
      ph[c].push_back(h); pl[c].push_back(l);
    end
  endtask

  task automatic add_rand(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      ph[c].push_back(int'($urandom_range(2, 12)));
      pl[c].push_back(int'($urandom_range(2, 12)));
    end
  endtask

  // Waveform: idle low, one rise per listed period, a closing rise, then low.
  task automatic build_waves();
    for (int c = 0; c < NUM_CH; c++) begin
      wave_q[c].delete();
      if (ph[c].size() != 0) begin
        repeat (6) wave_q[c].push_back(1'b0);
        for (int k = 0; k < ph[c].size(); k++) begin
          repeat (ph[c][k]) wave_q[c].push_back(1'b1);
          repeat (pl[c][k]) wave_q[c].push_back(1'b0);
        end
        repeat (2) wave_q[c].push_back(1'b1);
      end
    end
  endtask

  task automatic pulse_start(input logic cm);
    @(negedge clk);
    start = 1'b1; cont_mode = cm;
    @(negedge clk);
    start = 1'b0; cont_mode = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic run_single(input string name, input bit poke_busy, input int bound);
    build_waves();
    sb_q.push_back(single_exp());
    pulse_start(1'b0);
    check({name, "_busy"}, busy, 1);
    if (poke_busy) begin
      repeat (10) @(negedge clk);
      pulse_start(1'b1);
    end
    wait_drained(name, bound);
  endtask

  // ---------------- mon_clk driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++)
        mon_clk[c] = (wave_q[c].size() != 0) ? wave_q[c].pop_front() : 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got pulse expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("busy_at_done", busy, 0);
        check("period_vld", period_vld, e.vld);
        check("tout", tout, e.tout);
        for (int c = 0; c < NUM_CH; c++) begin
          if (e.vld[c]) begin
            check($sformatf("period[%0d]", c), period[c*CNT_W +: CNT_W], e.per[c]);
`ifdef CLK_MON_DUTY_MEAS_EN
            check($sformatf("high_cnt[%0d]", c), high_cnt[c*CNT_W +: CNT_W], e.hi[c]);
`endif
          end
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      logic [CNT_W-1:0] cur;
      cur = period[c*CNT_W +: CNT_W];
      if (cont_chk && period_vld[c] && (!seen_vld[c] || cur != last_per[c])) begin
        if (chg_q[c].size() == 0) begin
          total++; bad++;
          $display("FAIL cont_update[%0d]: got %0d expected no update", c, cur);
        end else begin
          check($sformatf("cont_period[%0d]", c), cur, chg_q[c].pop_front());
        end
      end
      last_per[c] = cur;
      seen_vld[c] = period_vld[c];
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_period", period, 0);
    check("rst_vld", period_vld, 0);
    check("rst_tout", tout, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Fixed periods 4, 16, 1024.
    clear_lists();
    add_const(CH_MCLK, NPER, 2, 2);
    add_const(CH_BCLK, NPER, 8, 8);
    add_const(CH_LRCLK, NPER, 512, 512);
    run_single("fixed", 1'b0, 8000);

    // Alternating 5,6,5,6 on channel 0 gives the truncated mean 5.
    clear_lists();
    ph[CH_MCLK] = '{2, 3, 2, 3};
    pl[CH_MCLK] = '{3, 3, 3, 3};
    add_rand(CH_BCLK, NPER);
    add_rand(CH_LRCLK, NPER);
    run_single("jitter", 1'b0, 1000);

    // Random periods, with a start (cont_mode=1) issued while busy.
    for (int i = 0; i < 4; i++) begin
      clear_lists();
      for (int c = 0; c < NUM_CH; c++) add_rand(c, NPER);
      run_single($sformatf("rand%0d", i), 1'b1, 1000);
    end

    // Channel 2 never toggles: it times out in WAIT_FIRST.
    clear_lists();
    add_rand(CH_MCLK, NPER);
    add_rand(CH_BCLK, NPER);
    run_single("timeout", 1'b0, TIMEOUT + 500);

    // Continuous mode: channel 1 moves from 16 to 32, channel 0 jitters.
    clear_lists();
    add_rand(CH_MCLK, 3*NPER);
    add_const(CH_BCLK, 3*NPER, 8, 8);
    add_const(CH_BCLK, 3*NPER, 16, 16);
    add_const(CH_LRCLK, 2*NPER, 3, 4);
    for (int c = 0; c < NUM_CH; c++) begin
      int prev = -1;
      chg_q[c].delete();
      for (int w = 0; w < ph[c].size() / NPER; w++) begin
        if (win_per(c, w) != prev) chg_q[c].push_back(CNT_W'(win_per(c, w)));
        prev = win_per(c, w);
      end
    end
    begin
      exp_t e = '0;
      e.tout = '1;
      sb_q.push_back(e);
    end
    build_waves();
    cont_chk = 1'b1;
    pulse_start(1'b1);
    check("cont_busy", busy, 1);
    wait_drained("cont", 6000);
    cont_chk = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("cont_windows_left[%0d]", c), chg_q[c].size(), 0);

    // Reset while counting: outputs clear at once, results are discarded.
    clear_lists();
    for (int c = 0; c < NUM_CH; c++) add_rand(c, NPER);
    build_waves();
    pulse_start(1'b0);
    repeat (12) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_vld", period_vld, 0);
    check("mid_rst_tout", tout, 0);
    for (int c = 0; c < NUM_CH; c++) wave_q[c].delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    clear_lists();
    for (int c = 0; c < NUM_CH; c++) add_rand(c, NPER);
    run_single("after_reset", 1'b1, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
